// File: rtl/apb4_bridge_pkg.sv
// rtl/apb4_bridge_pkg.sv - shared types, defaults and slot decode helper for the APB4 bridge
package apb4_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SLV  = 2'd1,
    ERR_MISS = 2'd2,
    ERR_TMO  = 2'd3
  } err_code_e;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  function automatic logic slot_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/apb4_addr_dec.sv
// rtl/apb4_addr_dec.sv - base/mask address decoder, lowest matching slot wins
module apb4_addr_dec
  import apb4_bridge_pkg::*;
#(
  parameter int                    SLV_NUM  = 8,
  parameter logic [SLV_NUM*32-1:0] SLV_BASE = {SLV_NUM{32'h0}},
  parameter logic [SLV_NUM*32-1:0] SLV_MASK = {SLV_NUM{32'hFFFF_F000}},
  parameter int                    IDX_W    = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the top down so the last assignment belongs to the lowest hit.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = SLV_NUM - 1; i >= 0; i--) begin
      if (slot_hit(addr_i, SLV_BASE[32*i +: 32], SLV_MASK[32*i +: 32])) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/apb4_bridge_xbar.sv
// rtl/apb4_bridge_xbar.sv - valid/ready memory port to SLV_NUM APB4 slaves with miss, timeout and sticky error
module apb4_bridge_xbar
  import apb4_bridge_pkg::*;
#(
  parameter int                    SLV_NUM     = 8,
  parameter logic [SLV_NUM*32-1:0] SLV_BASE    = {SLV_NUM{32'h0}},
  parameter logic [SLV_NUM*32-1:0] SLV_MASK    = {SLV_NUM{32'hFFFF_F000}},
  parameter int                    TIMEOUT_CYC = 255,
  parameter logic [31:0]           ERR_RDATA   = ERR_RDATA_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  mmap_valid_i,
  input  logic [31:0]           mmap_addr_i,
  input  logic [31:0]           mmap_wdata_i,
  input  logic [3:0]            mmap_wstrb_i,
  output logic [31:0]           mmap_rdata_o,
  output logic                  mmap_ready_o,
  output logic                  mmap_err_o,
  output logic [31:0]           apb_paddr_o,
  output logic [2:0]            apb_pprot_o,
  output logic [SLV_NUM-1:0]    apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [31:0]           apb_pwdata_o,
  output logic [3:0]            apb_pstrb_o,
  input  logic [SLV_NUM-1:0]    apb_pready_i,
  input  logic [SLV_NUM*32-1:0] apb_prdata_i,
  input  logic [SLV_NUM-1:0]    apb_pslverr_i,
  output logic [31:0]           err_addr_o,
  output logic [1:0]            err_code_o,
  input  logic                  err_clr_i,
  output logic                  err_irq_o
);

  localparam int IDX_W   = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int TMO_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TMO_W   = (TMO_RAW < 8) ? 8 : ((TMO_RAW > 16) ? 16 : TMO_RAW);
  localparam bit TMO_EN  = (TIMEOUT_CYC > 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;

  apb4_addr_dec #(
    .SLV_NUM  (SLV_NUM),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IDX_W    (IDX_W)
  ) u_dec (
    .addr_i (mmap_addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  state_e             state_q, state_d;
  logic [SLV_NUM-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [3:0]         pstrb_q, pstrb_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        err_addr_q, err_addr_d;
  err_code_e          err_code_q, err_code_d;

  logic               new_err;
  err_code_e          new_code;
  logic [31:0]        new_addr;
  logic               sel_ready;
  logic               sel_slverr;
  logic [31:0]        sel_rdata;
  logic               tmo_hit;

  assign sel_ready  = apb_pready_i[idx_q];
  assign sel_slverr = apb_pslverr_i[idx_q];
  assign sel_rdata  = apb_prdata_i[32*idx_q +: 32];
  assign tmo_hit    = TMO_EN && (cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    err_addr_d = err_addr_q;
    err_code_d = err_code_q;
    new_err    = 1'b0;
    new_code   = ERR_NONE;
    new_addr   = paddr_q;

    case (state_q)
      ST_IDLE: begin
        if (mmap_valid_i) begin
          if (dec_hit) begin
            state_d   = ST_SETUP;
            psel_d    = SLV_NUM'(1) << dec_idx;
            penable_d = 1'b0;
            pwrite_d  = |mmap_wstrb_i;
            paddr_d   = mmap_addr_i;
            pwdata_d  = mmap_wdata_i;
            pstrb_d   = mmap_wstrb_i;
            idx_d     = dec_idx;
            cnt_d     = '0;
          end else begin
            state_d  = ST_RESP;
            ready_d  = 1'b1;
            err_d    = 1'b1;
            rdata_d  = ERR_RDATA;
            new_err  = 1'b1;
            new_code = ERR_MISS;
            new_addr = mmap_addr_i;
          end
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // pready is tested first so a response on the expiry cycle still completes normally.
        if (sel_ready) begin
          state_d   = ST_RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = sel_slverr;
          rdata_d   = pwrite_q ? 32'h0 : sel_rdata;
          new_err   = sel_slverr;
          new_code  = ERR_SLV;
        end else if (tmo_hit) begin
          state_d   = ST_RESP;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          err_d     = 1'b1;
          rdata_d   = ERR_RDATA;
          new_err   = 1'b1;
          new_code  = ERR_TMO;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (err_clr_i) begin
      err_code_d = ERR_NONE;
      err_addr_d = '0;
    end else if (new_err && (err_code_q == ERR_NONE)) begin
      err_code_d = new_code;
      err_addr_d = new_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      psel_q     <= '0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
      err_code_q <= err_code_d;
    end
  end

  assign mmap_ready_o  = ready_q;
  assign mmap_err_o    = err_q;
  assign mmap_rdata_o  = rdata_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pprot_o   = 3'b000;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_pwdata_o  = pwdata_q;
  assign apb_pstrb_o   = pstrb_q;
  assign err_addr_o    = err_addr_q;
  assign err_code_o    = err_code_q;
  assign err_irq_o     = (err_code_q != ERR_NONE);

endmodule

// File: tb/tb_apb4_bridge_xbar.sv
// tb/tb_apb4_bridge_xbar.sv - scoreboard bench for apb4_bridge_xbar with a 4-slot slave model
module tb_apb4_bridge_xbar;

  localparam int SLV_NUM = 4;
  localparam logic [SLV_NUM*32-1:0] BASE = {32'h0400_1000, 32'h0300_2000, 32'h0300_1000, 32'h0400_0000};
  localparam logic [SLV_NUM*32-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFF00_0000};

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  mmap_valid_i;
  logic [31:0]           mmap_addr_i;
  logic [31:0]           mmap_wdata_i;
  logic [3:0]            mmap_wstrb_i;
  logic [31:0]           mmap_rdata_o;
  logic                  mmap_ready_o;
  logic                  mmap_err_o;
  logic [31:0]           apb_paddr_o;
  logic [2:0]            apb_pprot_o;
  logic [SLV_NUM-1:0]    apb_psel_o;
  logic                  apb_penable_o;
  logic                  apb_pwrite_o;
  logic [31:0]           apb_pwdata_o;
  logic [3:0]            apb_pstrb_o;
  logic [SLV_NUM-1:0]    apb_pready_i;
  logic [SLV_NUM*32-1:0] apb_prdata_i;
  logic [SLV_NUM-1:0]    apb_pslverr_i;
  logic [31:0]           err_addr_o;
  logic [1:0]            err_code_o;
  logic                  err_clr_i;
  logic                  err_irq_o;

  apb4_bridge_xbar #(
    .SLV_NUM     (SLV_NUM),
    .SLV_BASE    (BASE),
    .SLV_MASK    (MASK),
    .TIMEOUT_CYC (8),
    .ERR_RDATA   (32'hDEAD_BEEF)
  ) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .mmap_valid_i  (mmap_valid_i),
    .mmap_addr_i   (mmap_addr_i),
    .mmap_wdata_i  (mmap_wdata_i),
    .mmap_wstrb_i  (mmap_wstrb_i),
    .mmap_rdata_o  (mmap_rdata_o),
    .mmap_ready_o  (mmap_ready_o),
    .mmap_err_o    (mmap_err_o),
    .apb_paddr_o   (apb_paddr_o),
    .apb_pprot_o   (apb_pprot_o),
    .apb_psel_o    (apb_psel_o),
    .apb_penable_o (apb_penable_o),
    .apb_pwrite_o  (apb_pwrite_o),
    .apb_pwdata_o  (apb_pwdata_o),
    .apb_pstrb_o   (apb_pstrb_o),
    .apb_pready_i  (apb_pready_i),
    .apb_prdata_i  (apb_prdata_i),
    .apb_pslverr_i (apb_pslverr_i),
    .err_addr_o    (err_addr_o),
    .err_code_o    (err_code_o),
    .err_clr_i     (err_clr_i),
    .err_irq_o     (err_irq_o)
  );

  always #5 clk = ~clk;

  // Slave model: each slot answers after wait_n ACCESS cycles unless hang is set.
  logic [31:0] slot_rdata [SLV_NUM];
  int          wait_n;
  bit          hang;
  bit          slv_err;
  int          acc_cnt;

  always @(posedge clk) begin
    if (!rst_n || !apb_penable_o) acc_cnt <= 0;
    else if (!(|apb_pready_i)) acc_cnt <= acc_cnt + 1;
  end

  always_comb begin
    for (int i = 0; i < SLV_NUM; i++) begin
      apb_pready_i[i]        = apb_psel_o[i] & apb_penable_o & !hang & (acc_cnt >= wait_n);
      apb_pslverr_i[i]       = apb_psel_o[i] & slv_err;
      apb_prdata_i[32*i +: 32] = slot_rdata[i];
    end
  end

  logic [3:0]  mon_sel;
  int          mon_cyc;
  logic [3:0]  mon_strb;
  logic        mon_wr;
  logic [31:0] mon_wdata;
  logic [2:0]  mon_prot;

  always @(negedge clk) begin
    if (rst_n && (|apb_psel_o)) begin
      mon_sel   = mon_sel | apb_psel_o;
      mon_cyc   = mon_cyc + 1;
      mon_strb  = apb_pstrb_o;
      mon_wr    = apb_pwrite_o;
      mon_wdata = apb_pwdata_o;
      mon_prot  = apb_pprot_o;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  sel;
    int          sel_cyc;
    logic [3:0]  strb;
    logic        wr;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                              input logic [3:0] sel, input int sel_cyc,
                              input logic [3:0] strb, input logic wr);
    exp_t e;
    e.rdata = rdata; e.err = err; e.lat = lat; e.sel = sel;
    e.sel_cyc = sel_cyc; e.strb = strb; e.wr = wr;
    return e;
  endfunction

  task automatic do_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input exp_t e, input bit clr0);
    exp_t g;
    int   cyc;
    bit   seen;
    sb_q.push_back(e);
    @(negedge clk);
    mon_sel = '0; mon_cyc = 0; mon_strb = '0; mon_wr = 1'b0; mon_wdata = '0; mon_prot = '0;
    mmap_addr_i  = addr;
    mmap_wdata_i = wdata;
    mmap_wstrb_i = wstrb;
    mmap_valid_i = 1'b1;
    err_clr_i    = clr0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      err_clr_i = 1'b0;
      if (mmap_ready_o) seen = 1'b1;
    end
    g = sb_q.pop_front();
    if (!seen) begin
      check_eq({tag, "_ready_seen"}, 32'(seen), 32'd1);
    end else begin
      check_eq({tag, "_lat"},   32'(cyc),         32'(g.lat));
      check_eq({tag, "_rdata"}, mmap_rdata_o,     g.rdata);
      check_eq({tag, "_err"},   32'(mmap_err_o),  32'(g.err));
      check_eq({tag, "_sel"},   32'(mon_sel),     32'(g.sel));
      check_eq({tag, "_selcyc"}, 32'(mon_cyc),    32'(g.sel_cyc));
      if (g.sel_cyc > 0) begin
        check_eq({tag, "_pstrb"},  32'(mon_strb), 32'(g.strb));
        check_eq({tag, "_pwrite"}, 32'(mon_wr),   32'(g.wr));
        check_eq({tag, "_pprot"},  32'(mon_prot), 32'd0);
        if (g.wr) check_eq({tag, "_pwdata"}, mon_wdata, wdata);
      end
    end
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(mmap_ready_o), 32'd0);
    mmap_valid_i = 1'b0;
    mmap_wstrb_i = '0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    check_eq("clr_irq",  32'(err_irq_o),  32'd0);
    check_eq("clr_code", 32'(err_code_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_cnt;
    rst_n = 1'b0; mmap_valid_i = 1'b0; mmap_addr_i = '0; mmap_wdata_i = '0;
    mmap_wstrb_i = '0; err_clr_i = 1'b0;
    wait_n = 0; hang = 1'b0; slv_err = 1'b0;
    slot_rdata[0] = 32'hC0DE_0000; slot_rdata[1] = 32'h1111_1111;
    slot_rdata[2] = 32'h1234_5678; slot_rdata[3] = 32'h3333_3333;
    mon_sel = '0; mon_cyc = 0; mon_strb = '0; mon_wr = 1'b0; mon_wdata = '0; mon_prot = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(mmap_ready_o),  32'd0);
    check_eq("rst_psel",  32'(apb_psel_o),    32'd0);
    check_eq("rst_pen",   32'(apb_penable_o), 32'd0);
    check_eq("rst_rdata", mmap_rdata_o,       32'd0);
    check_eq("rst_irq",   32'(err_irq_o),     32'd0);
    check_eq("rst_code",  32'(err_code_o),    32'd0);
    check_eq("rst_eaddr", err_addr_o,         32'd0);
    rst_n = 1'b1;

    wait_n = 0;
    do_req("rd_s2", 32'h0300_2004, 32'h0, 4'h0, mk(32'h1234_5678, 1'b0, 3, 4'b0100, 2, 4'h0, 1'b0), 1'b0);

    wait_n = 2;
    do_req("wr_s1", 32'h0300_1010, 32'hA5A5_A5A5, 4'b0011, mk(32'h0, 1'b0, 5, 4'b0010, 4, 4'h3, 1'b1), 1'b0);

    do_req("miss", 32'h0FFF_0000, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b1, 1, 4'b0000, 0, 4'h0, 1'b0), 1'b0);
    check_eq("miss_code",  32'(err_code_o), 32'd2);
    check_eq("miss_irq",   32'(err_irq_o),  32'd1);
    check_eq("miss_eaddr", err_addr_o,      32'h0FFF_0000);
    clear_err();

    hang = 1'b1;
    do_req("tmo", 32'h0300_2000, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b1, 10, 4'b0100, 9, 4'h0, 1'b0), 1'b0);
    check_eq("tmo_code",  32'(err_code_o), 32'd3);
    check_eq("tmo_eaddr", err_addr_o,      32'h0300_2000);
    hang = 1'b0;

    wait_n = 0; slv_err = 1'b1;
    do_req("slverr", 32'h0300_1004, 32'h0, 4'h0, mk(32'h1111_1111, 1'b1, 3, 4'b0010, 2, 4'h0, 1'b0), 1'b0);
    slv_err = 1'b0;
    check_eq("sticky_code",  32'(err_code_o), 32'd3);
    check_eq("sticky_eaddr", err_addr_o,      32'h0300_2000);
    clear_err();

    do_req("miss_clr", 32'h0800_0000, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 1'b1, 1, 4'b0000, 0, 4'h0, 1'b0), 1'b1);
    check_eq("clr_prio_code", 32'(err_code_o), 32'd0);
    check_eq("clr_prio_irq",  32'(err_irq_o),  32'd0);

    wait_n = 7;
    do_req("edge_rdy", 32'h0300_2008, 32'h0, 4'h0, mk(32'h1234_5678, 1'b0, 10, 4'b0100, 9, 4'h0, 1'b0), 1'b0);
    check_eq("edge_code", 32'(err_code_o), 32'd0);

    hang = 1'b1; wait_n = 0;
    @(negedge clk);
    mmap_addr_i = 32'h0300_2008; mmap_wstrb_i = 4'h0; mmap_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_mid_pen", 32'(apb_penable_o), 32'd1);
    rst_n = 1'b0; mmap_valid_i = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_psel",  32'(apb_psel_o),    32'd0);
    check_eq("rst_mid_pen0",  32'(apb_penable_o), 32'd0);
    check_eq("rst_mid_ready", 32'(mmap_ready_o),  32'd0);
    rst_n = 1'b1;
    rdy_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mmap_ready_o) rdy_cnt++;
    end
    check_eq("rst_no_ready", 32'(rdy_cnt), 32'd0);
    hang = 1'b0;

    do_req("post_rst", 32'h0300_2004, 32'h0, 4'h0, mk(32'h1234_5678, 1'b0, 3, 4'b0100, 2, 4'h0, 1'b0), 1'b0);

    wait_n = 1;
    do_req("overlap", 32'h0400_1008, 32'h0, 4'h0, mk(32'hC0DE_0000, 1'b0, 4, 4'b0001, 3, 4'h0, 1'b0), 1'b0);

    wait_n = 0;
    do_req("wr_s3", 32'h0400_1F00, 32'h0BAD_F00D, 4'b1000, mk(32'h0, 1'b0, 3, 4'b0001, 2, 4'h8, 1'b1), 1'b0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
